// File: rtl/ms_serial_mouse_rx_if.sv
// Signal bundle between the serial-mouse receiver and its consumer.
// The receiver takes the master side; the consumer drives rd and observes the packets.
interface ms_serial_mouse_rx_if;
  logic       rd;
  logic       pkt_valid;
  logic [7:0] dx;
  logic [7:0] dy;
  logic       lbut;
  logic       rbut;
  logic       id_seen;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rd,
    output pkt_valid, dx, dy, lbut, rbut, id_seen, frame_err, busy
  );

  modport slave (
    output rd,
    input  pkt_valid, dx, dy, lbut, rbut, id_seen, frame_err, busy
  );
endinterface

// File: rtl/ms_serial_mouse_rx.sv
// Microsoft serial-mouse receiver: 7N1 character decoder with 16x oversampling,
// sync-bit packet alignment and signed X/Y delta plus button reporting.
module ms_serial_mouse_rx #(
  parameter int CLKFREQ      = 50_000_000,
  parameter int BAUDRATE     = 1_200,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ms_serial_mouse_rx_if.master   bus
);

  localparam int                 DIV      = CLKFREQ / (BAUDRATE * 16);
  localparam int                 DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
  localparam int                 TO_W     = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TO_W-1:0]    TO_LIMIT = TO_W'(TIMEOUT_BITS);
  localparam logic [6:0]         ID_CHAR  = 7'h4D;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rd_s1, r_rd_s2, r_rd_q;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [3:0]         r_tick_cnt;
  logic [2:0]         r_bit_cnt;
  logic               r_samp7, r_samp8;
  logic [6:0]         r_shift;
  logic [TO_W-1:0]    r_to_cnt;
  logic [1:0]         r_idx;
  logic [6:0]         r_b1, r_b2;
  logic [7:0]         r_dx, r_dy;
  logic               r_lbut, r_rbut;
  logic               r_pkt_valid, r_id_seen, r_frame_err;

  logic w_fall, w_tick16, w_tick9, w_maj;
  logic w_restart, w_bit_take, w_char_ok, w_char_bad, w_timeout;

  // NOTE: synchronizer and edge flops reset to 1 (idle line) so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_s1 <= 1'b1;
      r_rd_s2 <= 1'b1;
      r_rd_q  <= 1'b1;
    end else begin
      r_rd_s1 <= bus.rd;
      r_rd_s2 <= r_rd_s1;
      r_rd_q  <= r_rd_s2;
    end
  end

  assign w_fall   = r_rd_q & ~r_rd_s2;
  assign w_tick16 = (r_div_cnt == DIV_LAST);
  assign w_tick9  = w_tick16 && (r_tick_cnt == 4'd9);
  assign w_maj    = (r_samp7 & r_samp8) | (r_samp7 & r_rd_s2) | (r_samp8 & r_rd_s2);
  assign w_timeout = (r_state == S_IDLE) && (r_idx != 2'd0) && (r_to_cnt == TO_LIMIT);

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_bit_take  = 1'b0;
    w_char_ok   = 1'b0;
    w_char_bad  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_restart   = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick16 && (r_tick_cnt == 4'd8))
          w_state_nxt = r_rd_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick9) begin
          w_bit_take = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick9) begin
          w_char_ok   = w_maj;
          w_char_bad  = ~w_maj;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit-slot timing. Slot 0 is the tail of the start bit, so its tick-9 sample is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samp7    <= 1'b1;
      r_samp8    <= 1'b1;
      r_shift    <= '0;
      r_to_cnt   <= '0;
    end else if (w_restart) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      if (w_tick16) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if (r_tick_cnt == 4'd7) r_samp7 <= r_rd_s2;
        if (r_tick_cnt == 4'd8) r_samp8 <= r_rd_s2;
        if ((r_tick_cnt == 4'd15) && (r_state == S_IDLE) && (r_idx != 2'd0)
            && (r_to_cnt != TO_LIMIT))
          r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_bit_take) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt != 3'd0) r_shift <= {w_maj, r_shift[6:1]};
      end
    end
  end

  // Packet assembler: a sync-bit character always restarts the packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= 2'd0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_lbut      <= 1'b0;
      r_rbut      <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_id_seen   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_id_seen   <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_char_bad) begin
        r_frame_err <= 1'b1;
        r_idx       <= 2'd0;
      end else if (w_char_ok) begin
        if (r_shift == ID_CHAR) r_id_seen <= 1'b1;
        if (r_shift[6]) begin
          r_b1  <= r_shift;
          r_idx <= 2'd1;
        end else begin
          unique case (r_idx)
            2'd1: begin
              r_b2  <= r_shift;
              r_idx <= 2'd2;
            end
            2'd2: begin
              r_idx       <= 2'd0;
              r_lbut      <= r_b1[5];
              r_rbut      <= r_b1[4];
              r_dx        <= {r_b1[1:0], r_b2[5:0]};
              r_dy        <= {r_b1[3:2], r_shift[5:0]};
              r_pkt_valid <= 1'b1;
            end
            default: r_idx <= 2'd0;
          endcase
        end
      end else if (w_timeout) begin
        r_idx <= 2'd0;
      end
    end
  end

  assign bus.pkt_valid = r_pkt_valid;
  assign bus.dx        = r_dx;
  assign bus.dy        = r_dy;
  assign bus.lbut      = r_lbut;
  assign bus.rbut      = r_rbut;
  assign bus.id_seen   = r_id_seen;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ms_serial_mouse_rx.sv
// Self-checking bench for ms_serial_mouse_rx: table of character sequences with
// hand-computed packets, plus directed glitch, timeout and mid-character reset sequences.
module tb_ms_serial_mouse_rx;

  localparam int CLKFREQ  = 76_800;          // DIV = 4, one bit = 64 clocks
  localparam int BAUDRATE = 1_200;
  localparam int BIT      = 64;

  logic clk;
  logic reset_n;

  ms_serial_mouse_rx_if bus ();

  ms_serial_mouse_rx #(
    .CLKFREQ      (CLKFREQ),
    .BAUDRATE     (BAUDRATE),
    .TIMEOUT_BITS (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int n_checks = 0;

  // Pulse monitor, sampled on the falling edge.
  int   n_pkt  = 0;
  int   n_id   = 0;
  int   n_fe   = 0;
  int   n_viol = 0;
  logic prev_pkt = 1'b0, prev_id = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (bus.pkt_valid) n_pkt <= n_pkt + 1;
    if (bus.id_seen)   n_id  <= n_id + 1;
    if (bus.frame_err) n_fe  <= n_fe + 1;
    if ((bus.pkt_valid && bus.id_seen) || (bus.pkt_valid && prev_pkt) ||
        (bus.id_seen && prev_id) || (bus.frame_err && prev_fe))
      n_viol <= n_viol + 1;
    prev_pkt <= bus.pkt_valid;
    prev_id  <= bus.id_seen;
    prev_fe  <= bus.frame_err;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 7N1 character, LSB first; a low stop bit is followed by one idle bit so the next start is an edge.
  task automatic send_char(input logic [6:0] c, input logic stop);
    bus.rd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 7; i++) begin
      bus.rd = c[i];
      wait_clks(BIT);
    end
    bus.rd = stop;
    wait_clks(BIT);
    bus.rd = 1'b1;
    if (!stop) wait_clks(BIT);
  endtask

  typedef struct {
    string          name;
    int             n;
    logic [2:0][6:0] chs;
    logic [2:0]     bad;
    int             e_pkt, e_id, e_fe;
    logic [7:0]     e_dx, e_dy;
    logic           e_l, e_r;
  } vec_t;

  function automatic vec_t mk(input string nm, input int n,
                              input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                              input logic [2:0] bad, input int p, input int id, input int fe,
                              input logic [7:0] x, input logic [7:0] y,
                              input logic l, input logic r);
    vec_t v;
    v.name = nm; v.n = n; v.chs = {c2, c1, c0}; v.bad = bad;
    v.e_pkt = p; v.e_id = id; v.e_fe = fe;
    v.e_dx = x; v.e_dy = y; v.e_l = l; v.e_r = r;
    return v;
  endfunction

  vec_t vecs [10];
  int   p0, i0, f0;

  task automatic snap();
    p0 = n_pkt; i0 = n_id; f0 = n_fe;
  endtask

  initial begin
    vecs[0] = mk("m_id",    1, 7'h4D, 7'h00, 7'h00, 3'b000, 0, 1, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[1] = mk("m_pkt",   2, 7'h05, 7'h3D, 7'h00, 3'b000, 1, 0, 0, 8'h45, 8'hFD, 1'b0, 1'b0);
    vecs[2] = mk("left",    3, 7'h6C, 7'h05, 7'h3D, 3'b000, 1, 0, 0, 8'h05, 8'hFD, 1'b1, 1'b0);
    vecs[3] = mk("both_7c", 3, 7'h7C, 7'h3F, 7'h00, 3'b000, 1, 0, 0, 8'h3F, 8'hC0, 1'b1, 1'b1);
    vecs[4] = mk("both_7f", 3, 7'h7F, 7'h3F, 7'h00, 3'b000, 1, 0, 0, 8'hFF, 8'hC0, 1'b1, 1'b1);
    vecs[5] = mk("ferr",    3, 7'h6C, 7'h05, 7'h3D, 3'b010, 0, 0, 1, 8'hFF, 8'hC0, 1'b1, 1'b1);
    vecs[6] = mk("recover", 3, 7'h6C, 7'h05, 7'h3D, 3'b000, 1, 0, 0, 8'h05, 8'hFD, 1'b1, 1'b0);
    vecs[7] = mk("resync",  3, 7'h7F, 7'h40, 7'h00, 3'b000, 0, 0, 0, 8'h05, 8'hFD, 1'b1, 1'b0);
    vecs[8] = mk("finish",  1, 7'h12, 7'h00, 7'h00, 3'b000, 1, 0, 0, 8'h00, 8'h12, 1'b0, 1'b0);
    vecs[9] = mk("orphan",  1, 7'h05, 7'h00, 7'h00, 3'b000, 0, 0, 0, 8'h00, 8'h12, 1'b0, 1'b0);

    bus.rd  = 1'b1;
    reset_n = 1'b0;
    wait_clks(5);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    reset_n = 1'b1;

    // Idle line for 10 bit-times
    snap();
    wait_clks(10 * BIT);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_dx",   32'(bus.dx),   32'd0);
    check("idle_dy",   32'(bus.dy),   32'd0);
    check("idle_btn",  32'({bus.lbut, bus.rbut}), 32'd0);
    check("idle_pulses", 32'(n_pkt - p0 + n_id - i0 + n_fe - f0), 32'd0);

    // Table-driven character sequences
    foreach (vecs[k]) begin
      snap();
      for (int c = 0; c < vecs[k].n; c++)
        send_char(vecs[k].chs[c], ~vecs[k].bad[c]);
      wait_clks(2 * BIT);
      check({vecs[k].name, "_pkt"},  32'(n_pkt - p0), 32'(vecs[k].e_pkt));
      check({vecs[k].name, "_id"},   32'(n_id - i0),  32'(vecs[k].e_id));
      check({vecs[k].name, "_ferr"}, 32'(n_fe - f0),  32'(vecs[k].e_fe));
      check({vecs[k].name, "_dx"},   32'(bus.dx),     32'(vecs[k].e_dx));
      check({vecs[k].name, "_dy"},   32'(bus.dy),     32'(vecs[k].e_dy));
      check({vecs[k].name, "_lbut"}, 32'(bus.lbut),   32'(vecs[k].e_l));
      check({vecs[k].name, "_rbut"}, 32'(bus.rbut),   32'(vecs[k].e_r));
    end

    // 0.3-bit glitch: START is entered, then abandoned at the tick-8 sample
    snap();
    bus.rd = 1'b0;
    wait_clks(BIT * 3 / 10);
    check("glitch_busy_rise", 32'(bus.busy), 32'd1);
    bus.rd = 1'b1;
    wait_clks(BIT);
    check("glitch_busy_fall", 32'(bus.busy), 32'd0);
    wait_clks(2 * BIT);
    check("glitch_pulses", 32'(n_pkt - p0 + n_id - i0 + n_fe - f0), 32'd0);

    // Inter-byte timeout after 20 idle bit-times drops the header
    snap();
    send_char(7'h6C, 1'b1);
    wait_clks(20 * BIT);
    send_char(7'h05, 1'b1);
    send_char(7'h3D, 1'b1);
    wait_clks(2 * BIT);
    check("timeout_pkt", 32'(n_pkt - p0), 32'd0);
    check("timeout_dy",  32'(bus.dy),     32'h12);

    // Reset during data bit 3 of byte 2
    send_char(7'h40, 1'b1);
    bus.rd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 3; i++) begin
      bus.rd = 1'(7'h2A >> i);
      wait_clks(BIT);
    end
    bus.rd = 1'b1;
    wait_clks(BIT / 2);
    reset_n = 1'b0;
    wait_clks(3);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_dy",   32'(bus.dy),   32'd0);
    wait_clks(BIT);
    reset_n = 1'b1;
    wait_clks(2 * BIT);
    snap();
    send_char(7'h40, 1'b1);
    send_char(7'h00, 1'b1);
    send_char(7'h00, 1'b1);
    wait_clks(2 * BIT);
    check("postrst_pkt",  32'(n_pkt - p0), 32'd1);
    check("postrst_dx",   32'(bus.dx),     32'd0);
    check("postrst_dy",   32'(bus.dy),     32'd0);
    check("postrst_btn",  32'({bus.lbut, bus.rbut}), 32'd0);
    check("postrst_id",   32'(n_id - i0),  32'd0);

    check("pulse_rules", 32'(n_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
